pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces hand-written per-stage registers with one valid/ready block that carries an opaque payload plus PC. It also provides an optional skid entry, flush with payload clearing, hazard-bubble insertion and saturating stall/bubble counters. Stage-specific fields are packed into `in_data` by the instantiating stage.

## Interface
- `DATA_W`, 64: payload width in bits; ≥1.
- `PC_W`, 32: PC field width.
- `SKID_EN`, 1: 1 = two-entry registered-ready skid buffer; 0 = single entry with combinational `in_ready`.
- `CLEAR_ON_KILL`, 1: 1 = payload and PC are zeroed when an entry is flushed or invalid; 0 = stale data is retained.
- `CNT_W`, 16: performance counter width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream has an entry.
- `in_ready`  out  1  block can accept this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `in_pc`  in  PC_W  upstream PC.
- `out_valid`  out  1  registered; head entry valid.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_data`  out  DATA_W  registered head payload.
- `out_pc`  out  PC_W  registered head PC.
- `flush`  in  1  kill all held entries and the current input.
- `bubble`  in  1  hazard hold; refuse input without killing held entries.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid && !out_ready`.
- `bubble_cnt`  out  CNT_W  saturating count of cycles with `bubble && in_valid && !flush`.

## Operation
- Handshake: an input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`. Payload and PC travel together unchanged.
- States: EMPTY (no entry), FULL (head entry only), SKID (head plus skid entry; only reachable when SKID_EN=1).
- `in_ready`:
  - SKID_EN=1: `!skid_valid && !bubble`. Registered; no combinational path from `out_ready`.
  - SKID_EN=0: `(!out_valid || out_ready) && !bubble`.
- Transitions when `flush`=0:
  - EMPTY + input transfer → FULL.
  - FULL + output transfer + input transfer → FULL; head is loaded from the input.
  - FULL + output transfer only → EMPTY.
  - FULL + input transfer only → SKID; the skid entry captures the input.
  - SKID + output transfer → FULL; the skid entry moves to the head.
  - SKID never accepts input.
- Priority: `flush` > `bubble` > normal flow.
- `flush`: next state is EMPTY from any state. The input transfer in that cycle is dropped even if `in_ready` was high. If CLEAR_ON_KILL=1, head and skid payload/PC are zeroed.
- `bubble`:
  - Forces `in_ready`=0.
  - Held entries still drain to downstream.
  - When the head drains, `out_valid` falls; this is the bubble.
  - If CLEAR_ON_KILL=1, the emptied head's payload/PC are zeroed.
- Counters: increment by 1 per qualifying cycle and saturate at 2^CNT_W−1. Cleared only by `rst`. Not affected by `flush`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_pc`=0, `stall_cnt`=0, `bubble_cnt`=0. State is EMPTY and the skid entry is invalid. `in_ready` is 1 after reset (for either SKID_EN value) provided `bubble`=0.
- Latency: an input transfer at edge N gives `out_valid`=1 with that payload after edge N.
- Throughput: 1 transfer/cycle when `out_ready` stays high.
- Backpressure (SKID_EN=1): `in_ready` falls one cycle after `out_ready` falls. At most 2 entries are held.
- Simultaneous `flush` and `out_ready`: the head is still considered transferred downstream in that cycle. The downstream stage is responsible for ignoring it under its own flush.
- Reset mid-transfer: asynchronous; all entries are discarded immediately and counters are cleared.
- Ordering: strict FIFO; the skid entry never overtakes the head.

## Structure
- Shared package `pipe_pkg` holds:
  - state encodings `PS_EMPTY`=2'd0, `PS_FULL`=2'd1, `PS_SKID`=2'd2;
  - a saturating-increment function shared with other perf counters.
- One natural sub-module: `sat_counter` (CNT_W, enable, saturate), instantiated twice.
- Stage-specific packing/unpacking of `in_data` is done by callers, not inside this block.

## Test plan
- Reset then stream, `out_ready`=1: drive 4 entries with PC 0x100, 0x104, 0x108, 0x10C → the same sequence appears one cycle later, back-to-back, `stall_cnt`=0.
- Backpressure (SKID_EN=1): with FULL holding 0xA and input 0xB valid, drop `out_ready` for 3 cycles → state SKID, `in_ready`=0, `stall_cnt`=3. Raise `out_ready` → outputs 0xA then 0xB, with no loss or duplication.
- Flush in SKID with `in_valid`=1 carrying 0xC: assert `flush` for one cycle → next cycle `out_valid`=0, `out_data`=0, `out_pc`=0 (CLEAR_ON_KILL=1); 0xC is never output.
- Bubble: hold `bubble` for 2 cycles with `in_valid`=1 while FULL and `out_ready`=1 → head drains, `out_valid`=0 for 2 cycles, `bubble_cnt`=2, the input is accepted on the cycle after `bubble` drops.
- SKID_EN=0: toggle `out_ready` each cycle → `in_ready` tracks it combinationally, never more than 1 entry is held, and data order is preserved.
- Counter saturation (CNT_W=4): hold `out_valid`=1, `out_ready`=0 for 20 cycles → `stall_cnt`=15. Then assert `rst` mid-stall → all outputs return to reset values immediately.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-register definitions: occupancy state encodings and a
// saturating-increment helper used by performance counters.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } ps_state_t;

  // Returns v+1, clamped at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake, flush/bubble control and perf counters
// for one pipeline-stage boundary.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;
  logic              flush;
  logic              bubble;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  modport slave (
    input  in_valid, in_data, in_pc, out_ready, flush, bubble,
    output in_ready, out_valid, out_data, out_pc, stall_cnt, bubble_cnt
  );

  modport master (
    output in_valid, in_data, in_pc, out_ready, flush, bubble,
    input  in_ready, out_valid, out_data, out_pc, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter; counts enabled cycles and sticks at all-ones.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= CNT_W'(sat_inc(64'(r_cnt), CNT_W));
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register carrying payload + PC, with optional
// skid entry, flush, hazard bubble and stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int PC_W          = 32,
  parameter bit SKID_EN       = 1'b1,
  parameter bit CLEAR_ON_KILL = 1'b1,
  parameter int CNT_W         = 16
) (
  input logic           clk,
  input logic           rst,
  pipe_stage_reg_if.slave bus
);
  ps_state_t         r_state, w_state_next;
  logic [DATA_W-1:0] r_head_data, w_head_data_next;
  logic [PC_W-1:0]   r_head_pc, w_head_pc_next;
  logic [DATA_W-1:0] r_skid_data, w_skid_data_next;
  logic [PC_W-1:0]   r_skid_pc, w_skid_pc_next;
  logic              w_out_valid, w_in_ready, w_in_xfer, w_out_xfer;
  logic [1:0]        w_cnt_en;
  logic [CNT_W-1:0]  w_cnt [2];

  assign w_out_valid = (r_state != PS_EMPTY);

  // Skid mode takes ready from state only, cutting the out_ready -> in_ready path.
  generate
    if (SKID_EN) begin : g_rdy_skid
      assign w_in_ready = (r_state != PS_SKID) && !bus.bubble;
    end else begin : g_rdy_comb
      assign w_in_ready = (!w_out_valid || bus.out_ready) && !bus.bubble;
    end
  endgenerate

  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_out_xfer = w_out_valid && bus.out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_head_data_next = r_head_data;
    w_head_pc_next   = r_head_pc;
    w_skid_data_next = r_skid_data;
    w_skid_pc_next   = r_skid_pc;
    if (bus.flush) begin
      w_state_next = PS_EMPTY;
      if (CLEAR_ON_KILL) begin
        w_head_data_next = '0;
        w_head_pc_next   = '0;
        w_skid_data_next = '0;
        w_skid_pc_next   = '0;
      end
    end else begin
      case (r_state)
        PS_EMPTY: begin
          if (w_in_xfer) begin
            w_state_next     = PS_FULL;
            w_head_data_next = bus.in_data;
            w_head_pc_next   = bus.in_pc;
          end
        end
        PS_FULL: begin
          if (w_in_xfer && w_out_xfer) begin
            w_head_data_next = bus.in_data;
            w_head_pc_next   = bus.in_pc;
          end else if (w_out_xfer) begin
            w_state_next = PS_EMPTY;
            if (CLEAR_ON_KILL) begin
              w_head_data_next = '0;
              w_head_pc_next   = '0;
            end
          end else if (w_in_xfer) begin
            w_state_next     = PS_SKID;
            w_skid_data_next = bus.in_data;
            w_skid_pc_next   = bus.in_pc;
          end
        end
        PS_SKID: begin
          if (w_out_xfer) begin
            w_state_next     = PS_FULL;
            w_head_data_next = r_skid_data;
            w_head_pc_next   = r_skid_pc;
            if (CLEAR_ON_KILL) begin
              w_skid_data_next = '0;
              w_skid_pc_next   = '0;
            end
          end
        end
        default: w_state_next = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PS_EMPTY;
      r_head_data <= '0;
      r_head_pc   <= '0;
      r_skid_data <= '0;
      r_skid_pc   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_head_data <= w_head_data_next;
      r_head_pc   <= w_head_pc_next;
      r_skid_data <= w_skid_data_next;
      r_skid_pc   <= w_skid_pc_next;
    end
  end

  assign w_cnt_en[0] = w_out_valid && !bus.out_ready;
  assign w_cnt_en[1] = bus.bubble && bus.in_valid && !bus.flush;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_cnt_en[gi]),
        .o_cnt (w_cnt[gi])
      );
    end
  endgenerate

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = r_head_data;
  assign bus.out_pc     = r_head_pc;
  assign bus.stall_cnt  = w_cnt[0];
  assign bus.bubble_cnt = w_cnt[1];
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid instance (CNT_W=4) and combinational-ready instance.
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(16), .PC_W(32), .CNT_W(4)) a_if ();
  pipe_stage_reg_if #(.DATA_W(16), .PC_W(32), .CNT_W(4)) b_if ();

  pipe_stage_reg #(.DATA_W(16), .PC_W(32), .SKID_EN(1'b1), .CLEAR_ON_KILL(1'b1), .CNT_W(4)) dut_a (
    .clk (clk), .rst (rst), .bus (a_if.slave)
  );
  pipe_stage_reg #(.DATA_W(16), .PC_W(32), .SKID_EN(1'b0), .CLEAR_ON_KILL(1'b1), .CNT_W(4)) dut_b (
    .clk (clk), .rst (rst), .bus (b_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [15:0] d, input logic [31:0] pc);
    a_if.in_valid = v;
    a_if.in_data  = d;
    a_if.in_pc    = pc;
  endtask

  initial begin
    logic        exp_rdy_b [6];
    logic [15:0] exp_dat_b [6];
    int          b_next;
    exp_rdy_b = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_dat_b = '{16'h50, 16'h51, 16'h51, 16'h52, 16'h52, 16'h53};

    rst = 1'b1;
    drive_a(1'b0, 16'h0, 32'h0);
    a_if.out_ready = 1'b1; a_if.flush = 1'b0; a_if.bubble = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_pc = '0;
    b_if.out_ready = 1'b1; b_if.flush = 1'b0; b_if.bubble = 1'b0;
    tick(); tick();
    check("rst_out_valid", 64'(a_if.out_valid), 64'd0);
    check("rst_out_data", 64'(a_if.out_data), 64'd0);
    check("rst_out_pc", 64'(a_if.out_pc), 64'd0);
    check("rst_stall_cnt", 64'(a_if.stall_cnt), 64'd0);
    check("rst_bubble_cnt", 64'(a_if.bubble_cnt), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready_a", 64'(a_if.in_ready), 64'd1);
    check("rst_in_ready_b", 64'(b_if.in_ready), 64'd1);

    // Streaming with out_ready held high
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 16'h10 + 16'(i), 32'h100 + 32'(4 * i));
      tick();
      check("stream_valid", 64'(a_if.out_valid), 64'd1);
      check("stream_data", 64'(a_if.out_data), 64'h10 + 64'(i));
      check("stream_pc", 64'(a_if.out_pc), 64'h100 + 64'(4 * i));
    end
    drive_a(1'b0, 16'h0, 32'h0);
    tick();
    check("stream_drain_valid", 64'(a_if.out_valid), 64'd0);
    check("stream_drain_data", 64'(a_if.out_data), 64'd0);
    check("stream_stall_cnt", 64'(a_if.stall_cnt), 64'd0);

    // Backpressure into the skid entry
    drive_a(1'b1, 16'hA, 32'h200);
    tick();
    a_if.out_ready = 1'b0;
    drive_a(1'b1, 16'hB, 32'h204);
    #1;
    check("bp_in_ready_before", 64'(a_if.in_ready), 64'd1);
    tick();
    drive_a(1'b0, 16'h0, 32'h0);
    tick(); tick();
    check("bp_in_ready_skid", 64'(a_if.in_ready), 64'd0);
    check("bp_stall_cnt", 64'(a_if.stall_cnt), 64'd3);
    check("bp_head_data", 64'(a_if.out_data), 64'hA);
    a_if.out_ready = 1'b1;
    tick();
    check("bp_second_valid", 64'(a_if.out_valid), 64'd1);
    check("bp_second_data", 64'(a_if.out_data), 64'hB);
    check("bp_second_pc", 64'(a_if.out_pc), 64'h204);
    check("bp_stall_hold", 64'(a_if.stall_cnt), 64'd3);
    tick();
    check("bp_empty", 64'(a_if.out_valid), 64'd0);

    // Flush while holding two entries and a pending input
    drive_a(1'b1, 16'h1, 32'h300);
    tick();
    a_if.out_ready = 1'b0;
    drive_a(1'b1, 16'h2, 32'h304);
    tick();
    drive_a(1'b1, 16'hC, 32'h308);
    a_if.flush = 1'b1;
    tick();
    a_if.flush = 1'b0;
    drive_a(1'b0, 16'h0, 32'h0);
    a_if.out_ready = 1'b1;
    check("flush_valid", 64'(a_if.out_valid), 64'd0);
    check("flush_data", 64'(a_if.out_data), 64'd0);
    check("flush_pc", 64'(a_if.out_pc), 64'd0);
    check("flush_stall_cnt", 64'(a_if.stall_cnt), 64'd5);
    tick();
    check("flush_no_c", 64'(a_if.out_valid), 64'd0);

    // Hazard bubble while FULL
    drive_a(1'b1, 16'h30, 32'h400);
    tick();
    drive_a(1'b1, 16'h31, 32'h404);
    a_if.bubble = 1'b1;
    #1;
    check("bub_in_ready", 64'(a_if.in_ready), 64'd0);
    tick();
    check("bub_drain1_valid", 64'(a_if.out_valid), 64'd0);
    check("bub_drain1_data", 64'(a_if.out_data), 64'd0);
    tick();
    check("bub_drain2_valid", 64'(a_if.out_valid), 64'd0);
    check("bub_cnt", 64'(a_if.bubble_cnt), 64'd2);
    a_if.bubble = 1'b0;
    #1;
    check("bub_release_ready", 64'(a_if.in_ready), 64'd1);
    tick();
    drive_a(1'b0, 16'h0, 32'h0);
    check("bub_accept_valid", 64'(a_if.out_valid), 64'd1);
    check("bub_accept_data", 64'(a_if.out_data), 64'h31);
    check("bub_accept_pc", 64'(a_if.out_pc), 64'h404);
    tick();

    // Single-entry mode with toggling out_ready
    b_next = 0;
    b_if.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b_if.in_data   = 16'h50 + 16'(b_next);
      b_if.in_pc     = 32'h500 + 32'(4 * b_next);
      b_if.out_ready = (k % 2 == 1);
      #1;
      check("b_in_ready", 64'(b_if.in_ready), 64'(exp_rdy_b[k]));
      tick();
      if (exp_rdy_b[k]) b_next++;
      check("b_out_valid", 64'(b_if.out_valid), 64'd1);
      check("b_out_data", 64'(b_if.out_data), 64'(exp_dat_b[k]));
    end
    b_if.in_valid = 1'b0;

    // Stall counter saturation, then asynchronous reset mid-stall
    rst = 1'b1;
    #1;
    rst = 1'b0;
    a_if.out_ready = 1'b0;
    drive_a(1'b1, 16'h77, 32'h600);
    tick();
    drive_a(1'b0, 16'h0, 32'h0);
    repeat (20) tick();
    check("sat_stall_cnt", 64'(a_if.stall_cnt), 64'd15);
    check("sat_head_data", 64'(a_if.out_data), 64'h77);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(a_if.out_valid), 64'd0);
    check("arst_data", 64'(a_if.out_data), 64'd0);
    check("arst_pc", 64'(a_if.out_pc), 64'd0);
    check("arst_stall_cnt", 64'(a_if.stall_cnt), 64'd0);
    check("arst_in_ready", 64'(a_if.in_ready), 64'd1);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
